// File: rtl/sparc_mem_pkg.sv
// sparc_mem_pkg: shared definitions for the SPARC memory controller.
//   - transfer size codes carried on Type
//   - RW encoding (1 = load, 0 = store)
//   - controller FSM state encoding
//   - alignment helper used by the controller
package sparc_mem_pkg;

  localparam logic [1:0] TYPE_BYTE  = 2'b00;
  localparam logic [1:0] TYPE_HALF  = 2'b01;
  localparam logic [1:0] TYPE_WORD  = 2'b10;
  localparam logic [1:0] TYPE_DWORD = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_ACC0 = 3'd2,
    ST_ACC1 = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Natural alignment: halfword on 2, word on 4, doubleword on 8 bytes.
  function automatic logic is_aligned(input logic [1:0] typ, input logic [2:0] a);
    logic ok;
    ok = 1'b1;
    case (typ)
      TYPE_HALF:  ok = (a[0] == 1'b0);
      TYPE_WORD:  ok = (a[1:0] == 2'b00);
      TYPE_DWORD: ok = (a == 3'b000);
      default:    ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/sparc_word_ram.sv
// sparc_word_ram: single-port 32-bit word array.
//   i_clk   : write clock (rising edge)
//   i_idx   : word index, shared by read and write
//   i_wdata : write data, lane l is bits [8l+7:8l]
//   i_wbe   : per-lane write enable, bit 3 = bits [31:24]
//   o_rdata : combinational read of the indexed word
// Contents are never reset.
module sparc_word_ram #(
  parameter int IDX_WIDTH = 7
) (
  input  logic                 i_clk,
  input  logic [IDX_WIDTH-1:0] i_idx,
  input  logic [31:0]          i_wdata,
  input  logic [3:0]           i_wbe,
  output logic [31:0]          o_rdata
);

  logic [31:0] r_mem [2**IDX_WIDTH];

  always_ff @(posedge i_clk) begin
    for (int l = 0; l < 4; l++) begin
      if (i_wbe[l]) r_mem[i_idx][l*8 +: 8] <= i_wdata[l*8 +: 8];
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/sparc_mem_ctrl.sv
// sparc_mem_ctrl: big-endian memory behind the SPARC MPU datapath.
//   Clk, Clr        : clock (rising edge), async active-low reset
//   MOV, RW         : request valid / 1 = load, 0 = store
//   Type, SignExt   : transfer size, sign-extend sub-word loads
//   Address         : byte address (low ADDR_WIDTH bits decoded)
//   DataIn/DataIn2  : store data (even / odd word of a doubleword)
//   DataOut/DataOut2: registered load results
//   MOC, MisAlign   : completion and misalignment flag (registered)
//   o_dbg_state     : current FSM state for observation
// Handshake: MOV high in IDLE is accepted and all request fields are
// latched; MOV is then ignored until DONE. MOC stays high while MOV is
// high and drops after the first edge that samples MOV low, so a new
// request always needs MOV to go low for at least one edge.
module sparc_mem_ctrl
  import sparc_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int LATENCY    = 2
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        MOV,
  input  logic        RW,
  input  logic [1:0]  Type,
  input  logic        SignExt,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  input  logic [31:0] DataIn2,
  output logic [31:0] DataOut,
  output logic [31:0] DataOut2,
  output logic        MOC,
  output logic        MisAlign,
  output logic [2:0]  o_dbg_state
);

  localparam int IDX_WIDTH = ADDR_WIDTH - 2;

  state_t                r_state, w_state_next;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_type;
  logic                  r_rw, r_sext;
  logic [31:0]           r_din, r_din2, r_dout, r_dout2;
  logic                  r_moc, r_misalign;

  logic                  w_aligned, w_access;
  logic [IDX_WIDTH-1:0]  w_idx;
  logic [31:0]           w_wdata, w_rdata, w_load;
  logic [3:0]            w_lane_be, w_wbe;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic                  w_unused_addr;

  // Upper address bits wrap away.
  assign w_unused_addr = ^Address[31:ADDR_WIDTH];

  // ---------------- FSM ----------------
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (MOV) w_state_next = ST_WAIT;
      ST_WAIT: if (r_cnt == 4'd0) w_state_next = ST_ACC0;
      // Misaligned doublewords also pass through ACC1 so the abort
      // costs the same latency as a real doubleword.
      ST_ACC0: w_state_next = (r_type == TYPE_DWORD) ? ST_ACC1 : ST_DONE;
      ST_ACC1: w_state_next = ST_DONE;
      ST_DONE: if (!MOV) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ---------------- array access ----------------
  always_comb begin
    w_aligned = is_aligned(r_type, r_addr[2:0]);
    w_access  = w_aligned && ((r_state == ST_ACC0) || (r_state == ST_ACC1));

    w_idx = r_addr[ADDR_WIDTH-1:2];
    if (r_state == ST_ACC1) w_idx[0] = 1'b1;

    // Sub-word data is replicated across lanes; the enable picks the lane.
    w_wdata   = r_din;
    w_lane_be = 4'b1111;
    case (r_type)
      TYPE_BYTE: begin
        w_wdata   = {4{r_din[7:0]}};
        w_lane_be = 4'b1000 >> r_addr[1:0];
      end
      TYPE_HALF: begin
        w_wdata   = {2{r_din[15:0]}};
        w_lane_be = r_addr[1] ? 4'b0011 : 4'b1100;
      end
      TYPE_DWORD: if (r_state == ST_ACC1) w_wdata = r_din2;
      default: ;
    endcase
    w_wbe = (w_access && r_rw == RW_WRITE) ? w_lane_be : 4'b0000;

    // Big-endian lane extraction for loads.
    case (r_addr[1:0])
      2'd0:    w_byte = w_rdata[31:24];
      2'd1:    w_byte = w_rdata[23:16];
      2'd2:    w_byte = w_rdata[15:8];
      default: w_byte = w_rdata[7:0];
    endcase
    w_half = r_addr[1] ? w_rdata[15:0] : w_rdata[31:16];

    case (r_type)
      TYPE_BYTE: w_load = {{24{r_sext & w_byte[7]}}, w_byte};
      TYPE_HALF: w_load = {{16{r_sext & w_half[15]}}, w_half};
      default:   w_load = w_rdata;
    endcase
  end

  sparc_word_ram #(.IDX_WIDTH(IDX_WIDTH)) u_ram (
    .i_clk   (Clk),
    .i_idx   (w_idx),
    .i_wdata (w_wdata),
    .i_wbe   (w_wbe),
    .o_rdata (w_rdata)
  );

  // ---------------- datapath registers ----------------
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      r_cnt      <= 4'd0;
      r_addr     <= '0;
      r_type     <= TYPE_BYTE;
      r_rw       <= RW_WRITE;
      r_sext     <= 1'b0;
      r_din      <= 32'd0;
      r_din2     <= 32'd0;
      r_dout     <= 32'd0;
      r_dout2    <= 32'd0;
      r_moc      <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && MOV) begin
        r_addr <= Address[ADDR_WIDTH-1:0];
        r_type <= Type;
        r_rw   <= RW;
        r_sext <= SignExt;
        r_din  <= DataIn;
        r_din2 <= DataIn2;
        r_cnt  <= 4'(LATENCY - 1);
      end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end

      if (w_access && r_rw == RW_READ) begin
        if (r_state == ST_ACC0) r_dout  <= w_load;
        else                    r_dout2 <= w_rdata;
      end

      // Request fields are frozen until IDLE, so w_aligned is stable in DONE.
      r_moc      <= (w_state_next == ST_DONE);
      r_misalign <= (w_state_next == ST_DONE) && !w_aligned;
    end
  end

  assign DataOut     = r_dout;
  assign DataOut2    = r_dout2;
  assign MOC         = r_moc;
  assign MisAlign    = r_misalign;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sparc_mem_ctrl.sv
module tb_sparc_mem_ctrl;
  import sparc_mem_pkg::*;

  localparam int AW  = 9;
  localparam int LAT = 2;
  localparam int W   = 73;  // {misalign, dout, dout2, latency[7:0]}

  // ---------------- clock / reset ----------------
  logic        Clk = 1'b0;
  logic        Clr, MOV, RW, SignExt;
  logic [1:0]  Type;
  logic [31:0] Address, DataIn, DataIn2, DataOut, DataOut2;
  logic        MOC, MisAlign;
  logic [2:0]  o_dbg_state;

  always #5 Clk = ~Clk;

  sparc_mem_ctrl #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .Clk(Clk), .Clr(Clr), .MOV(MOV), .RW(RW), .Type(Type), .SignExt(SignExt),
    .Address(Address), .DataIn(DataIn), .DataIn2(DataIn2),
    .DataOut(DataOut), .DataOut2(DataOut2), .MOC(MOC), .MisAlign(MisAlign),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  logic [7:0]   m_mem [2**AW];
  logic [31:0]  m_dout  = 32'd0;
  logic [31:0]  m_dout2 = 32'd0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] wrap(input int v);
    return AW'(v);
  endfunction

  // Byte-addressed reference model; pushes the expected completion.
  task automatic model_req(input logic rw, input logic [1:0] typ, input logic sext,
                           input logic [31:0] addr, input logic [31:0] din, input logic [31:0] din2);
    int   a;
    logic mis;
    logic [7:0]  lat;
    logic [15:0] h;
    a   = int'(addr[AW-1:0]);
    mis = (typ == TYPE_HALF  && addr[0]) ||
          (typ == TYPE_WORD  && addr[1:0] != 2'b00) ||
          (typ == TYPE_DWORD && addr[2:0] != 3'b000);
    lat = (typ == TYPE_DWORD) ? 8'(LAT + 2) : 8'(LAT + 1);
    if (!mis) begin
      if (rw == RW_WRITE) begin
        case (typ)
          TYPE_BYTE: m_mem[wrap(a)] = din[7:0];
          TYPE_HALF: begin
            m_mem[wrap(a)]   = din[15:8];
            m_mem[wrap(a+1)] = din[7:0];
          end
          TYPE_WORD: for (int i = 0; i < 4; i++) m_mem[wrap(a+i)] = din[31-8*i -: 8];
          default: for (int i = 0; i < 4; i++) begin
            m_mem[wrap(a+i)]   = din[31-8*i -: 8];
            m_mem[wrap(a+4+i)] = din2[31-8*i -: 8];
          end
        endcase
      end else begin
        case (typ)
          TYPE_BYTE: m_dout = {{24{sext & m_mem[wrap(a)][7]}}, m_mem[wrap(a)]};
          TYPE_HALF: begin
            h = {m_mem[wrap(a)], m_mem[wrap(a+1)]};
            m_dout = {{16{sext & h[15]}}, h};
          end
          TYPE_WORD: for (int i = 0; i < 4; i++) m_dout[31-8*i -: 8] = m_mem[wrap(a+i)];
          default: for (int i = 0; i < 4; i++) begin
            m_dout[31-8*i -: 8]  = m_mem[wrap(a+i)];
            m_dout2[31-8*i -: 8] = m_mem[wrap(a+4+i)];
          end
        endcase
      end
    end
    exp_q.push_back({mis, m_dout, m_dout2, lat});
  endtask

  // ---------------- driver ----------------
  // Called right after an edge (+#1) with the DUT in IDLE; returns the same way.
  task automatic do_req(input logic rw, input logic [1:0] typ, input logic sext,
                        input logic [31:0] addr, input logic [31:0] din, input logic [31:0] din2,
                        input int hold);
    logic [W-1:0] e;
    int lat;
    model_req(rw, typ, sext, addr, din, din2);
    RW = rw; Type = typ; SignExt = sext; Address = addr; DataIn = din; DataIn2 = din2;
    MOV = 1'b1;
    @(posedge Clk); #1;
    // Request fields must have been latched at acceptance.
    Address = $urandom; DataIn = $urandom; DataIn2 = $urandom;
    Type = 2'($urandom_range(0, 3)); RW = ~rw; SignExt = ~sext;
    lat = 0;
    while (!MOC && lat < 40) begin
      @(posedge Clk); #1;
      lat++;
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    if (!MOC) begin
      check("moc_timeout", 64'(MOC), 64'd1);
    end else begin
      check("misalign", 64'(MisAlign), 64'(e[72]));
      check("dout",     64'(DataOut),  64'(e[71:40]));
      check("dout2",    64'(DataOut2), 64'(e[39:8]));
      check("latency",  64'(lat),      64'(e[7:0]));
      for (int i = 0; i < hold; i++) begin
        @(posedge Clk); #1;
        check("hold_moc",   64'(MOC),         64'd1);
        check("hold_state", 64'(o_dbg_state), 64'(ST_DONE));
        check("hold_dout",  64'(DataOut),     64'(e[71:40]));
      end
    end
    MOV = 1'b0;
    @(posedge Clk); #1;
    check("moc_fall",   64'(MOC),         64'd0);
    check("mis_fall",   64'(MisAlign),    64'd0);
    check("idle_after", 64'(o_dbg_state), 64'(ST_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    Clr = 1'b0; MOV = 1'b0; RW = RW_READ; Type = TYPE_WORD; SignExt = 1'b0;
    Address = 32'd0; DataIn = 32'd0; DataIn2 = 32'd0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_moc",   64'(MOC),         64'd0);
    check("rst_mis",   64'(MisAlign),    64'd0);
    check("rst_dout",  64'(DataOut),     64'd0);
    check("rst_dout2", 64'(DataOut2),    64'd0);
    check("rst_state", 64'(o_dbg_state), 64'(ST_IDLE));
    Clr = 1'b1;
    @(posedge Clk); #1;

    // Word store/load.
    do_req(RW_WRITE, TYPE_WORD, 1'b0, 32'h010, 32'hDEADBEEF, 32'h0, 0);
    do_req(RW_READ,  TYPE_WORD, 1'b0, 32'h010, 32'h0, 32'h0, 0);
    // Byte merge and extension.
    do_req(RW_WRITE, TYPE_WORD, 1'b0, 32'h010, 32'h11223344, 32'h0, 0);
    do_req(RW_WRITE, TYPE_BYTE, 1'b0, 32'h013, 32'hFFFFFF80, 32'h0, 0);
    do_req(RW_READ,  TYPE_BYTE, 1'b1, 32'h013, 32'h0, 32'h0, 0);
    do_req(RW_READ,  TYPE_BYTE, 1'b0, 32'h013, 32'h0, 32'h0, 0);
    do_req(RW_READ,  TYPE_WORD, 1'b0, 32'h010, 32'h0, 32'h0, 0);
    // Doubleword.
    do_req(RW_WRITE, TYPE_DWORD, 1'b0, 32'h018, 32'hAAAA0001, 32'hBBBB0002, 0);
    do_req(RW_READ,  TYPE_DWORD, 1'b0, 32'h018, 32'h0, 32'h0, 0);
    // Halfwords, aligned and misaligned.
    do_req(RW_WRITE, TYPE_WORD, 1'b0, 32'h020, 32'h8566F788, 32'h0, 0);
    do_req(RW_READ,  TYPE_HALF, 1'b1, 32'h022, 32'h0, 32'h0, 0);
    do_req(RW_READ,  TYPE_HALF, 1'b0, 32'h020, 32'h0, 32'h0, 0);
    do_req(RW_READ,  TYPE_HALF, 1'b1, 32'h021, 32'h0, 32'h0, 0);
    do_req(RW_WRITE, TYPE_HALF, 1'b0, 32'h021, 32'h0000FFFF, 32'h0, 0);
    do_req(RW_WRITE, TYPE_DWORD, 1'b0, 32'h024, 32'h0, 32'h0, 0);
    do_req(RW_READ,  TYPE_WORD, 1'b0, 32'h020, 32'h0, 32'h0, 0);
    // MOV held through DONE; address wraps above bit 8.
    do_req(RW_READ,  TYPE_WORD, 1'b0, 32'hFFFF_FE10, 32'h0, 32'h0, 5);

    // Reset during WAIT of a store: memory keeps the old word.
    do_req(RW_WRITE, TYPE_WORD, 1'b0, 32'h030, 32'hCAFEF00D, 32'h0, 0);
    RW = RW_WRITE; Type = TYPE_WORD; Address = 32'h030; DataIn = 32'h0BAD0BAD; MOV = 1'b1;
    @(posedge Clk); #1;
    check("wait_state", 64'(o_dbg_state), 64'(ST_WAIT));
    Clr = 1'b0;
    #1;
    check("clr_moc",   64'(MOC),         64'd0);
    check("clr_mis",   64'(MisAlign),    64'd0);
    check("clr_dout",  64'(DataOut),     64'd0);
    check("clr_dout2", 64'(DataOut2),    64'd0);
    check("clr_state", 64'(o_dbg_state), 64'(ST_IDLE));
    MOV = 1'b0;
    m_dout = 32'd0; m_dout2 = 32'd0;
    @(posedge Clk); #1;
    Clr = 1'b1;
    @(posedge Clk); #1;
    do_req(RW_READ, TYPE_WORD, 1'b0, 32'h030, 32'h0, 32'h0, 0);

    // Random traffic in a pre-filled window.
    for (int i = 0; i < 16; i++)
      do_req(RW_WRITE, TYPE_WORD, 1'b0, 32'h100 + 32'(4*i), $urandom, 32'h0, 0);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = (32'h100 + 32'($urandom_range(0, 63))) | ($urandom & 32'hFFFF_FE00);
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom, $urandom, $urandom_range(0, 2));
    end

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
